// File: rtl/nebula_inject_arbiter.sv
// Packet-atomic round-robin arbiter that shares one router injection port among NUM_REQ requesters.
// It has a registered output stage, flit and packet counters, and a runaway-packet watchdog.
module nebula_inject_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned MAX_PKT_FLITS = 16,
  parameter int unsigned FLIT_W        = 64,
  parameter int unsigned IDW           = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0][FLIT_W-1:0]   i_req_flit,
  input  logic [NUM_REQ-1:0]               i_req_valid,
  input  logic [NUM_REQ-1:0]               i_req_last,
  output logic [NUM_REQ-1:0]               o_req_ready,
  output logic [FLIT_W-1:0]                o_out_flit,
  output logic                             o_out_valid,
  input  logic                             i_out_ready,
  output logic [IDW-1:0]                   o_grant_id,
  output logic                             o_busy,
  output logic [31:0]                      o_flit_count,
  output logic [31:0]                      o_pkt_count,
  output logic                             o_pkt_err
);

  localparam int unsigned BCW = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } state_e;

  state_e             r_state;
  state_e             w_state_next;

  logic               r_out_valid;
  logic [FLIT_W-1:0]  r_out_flit;
  logic [IDW-1:0]     r_grant_id;
  logic [IDW-1:0]     r_rr_ptr;
  logic [BCW-1:0]     r_beat_cnt;
  logic [31:0]        r_flit_count;
  logic [31:0]        r_pkt_count;
  logic               r_pkt_err;

  logic               w_load_ok;
  logic [IDW-1:0]     w_pick;
  logic               w_pick_found;
  logic [IDW-1:0]     w_sel;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_accept;
  logic               w_last;
  logic [BCW-1:0]     w_beat_new;
  logic               w_wd_hit;
  logic               w_release;
  logic [FLIT_W-1:0]  w_flit_sel;

  function automatic logic [IDW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    return IDW'((base + off) % NUM_REQ);
  endfunction

  assign w_load_ok = !r_out_valid || i_out_ready;

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    w_pick       = '0;
    w_pick_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_pick_found && i_req_valid[wrap_idx(32'(r_rr_ptr), k)]) begin
        w_pick       = wrap_idx(32'(r_rr_ptr), k);
        w_pick_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_release) begin
          w_state_next = StLocked;
        end
      end
      StLocked: begin
        if (w_release) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Handshake outputs; rst_n gates ready so that no flit is taken while in reset.
  always_comb begin
    w_req_ready = '0;
    w_accept    = 1'b0;
    w_sel       = r_grant_id;
    w_beat_new  = r_beat_cnt + 1'b1;
    unique case (r_state)
      StIdle: begin
        w_sel                = w_pick;
        w_beat_new           = BCW'(1);
        w_accept             = w_pick_found && w_load_ok && rst_n;
        w_req_ready[w_pick]  = w_accept;
      end
      StLocked: begin
        w_accept                = i_req_valid[r_grant_id] && w_load_ok && rst_n;
        w_req_ready[r_grant_id] = w_load_ok && rst_n;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
    w_last     = i_req_last[w_sel];
    w_wd_hit   = (w_beat_new == BCW'(MAX_PKT_FLITS));
    w_release  = w_accept && (w_last || w_wd_hit);
  end

  assign w_flit_sel = i_req_flit[w_sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_flit   <= '0;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
      r_beat_cnt   <= '0;
      r_flit_count <= '0;
      r_pkt_count  <= '0;
      r_pkt_err    <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_out_valid <= w_accept;
        if (w_accept) begin
          r_out_flit <= w_flit_sel;
        end
      end
      if (w_accept) begin
        r_grant_id   <= w_sel;
        r_beat_cnt   <= w_beat_new;
        r_flit_count <= r_flit_count + 32'd1;
      end
      if (w_release) begin
        r_rr_ptr    <= wrap_idx(32'(w_sel), 1);
        r_pkt_count <= r_pkt_count + 32'd1;
        if (!w_last) begin
          r_pkt_err <= 1'b1;
        end
      end
    end
  end

  assign o_req_ready  = w_req_ready;
  assign o_out_flit   = r_out_flit;
  assign o_out_valid  = r_out_valid;
  assign o_grant_id   = r_grant_id;
  assign o_busy       = (r_state == StLocked);
  assign o_flit_count = r_flit_count;
  assign o_pkt_count  = r_pkt_count;
  assign o_pkt_err    = r_pkt_err;

`ifndef SYNTHESIS
  a_ready_onehot: assert property (@(posedge clk) $onehot0(o_req_ready));

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (r_out_valid && !i_out_ready) |=> (r_out_valid && $stable(r_out_flit)));

  a_beat_bound: assert property (@(posedge clk) disable iff (!rst_n)
    r_beat_cnt <= BCW'(MAX_PKT_FLITS));

  a_grant_range: assert property (@(posedge clk) disable iff (!rst_n)
    32'(r_grant_id) < NUM_REQ);
`endif

endmodule

// File: tb/tb_nebula_inject_arbiter.sv
// Directed bench for nebula_inject_arbiter: a table of per-cycle vectors plus hand sequences
// for the single-flit start-up and reset-in-mid-packet cases.
module tb_nebula_inject_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned FW = 16;
  localparam int unsigned NV = 31;

  logic                  clk;
  logic                  rst_n;
  logic [NR-1:0][FW-1:0] req_flit;
  logic [NR-1:0]         req_valid;
  logic [NR-1:0]         req_last;
  logic [NR-1:0]         req_ready;
  logic [FW-1:0]         out_flit;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [31:0]           flit_count;
  logic [31:0]           pkt_count;
  logic                  pkt_err;

  int n_checks;
  int n_errors;

  nebula_inject_arbiter #(
    .NUM_REQ       (NR),
    .MAX_PKT_FLITS (4),
    .FLIT_W        (FW)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_req_flit   (req_flit),
    .i_req_valid  (req_valid),
    .i_req_last   (req_last),
    .o_req_ready  (req_ready),
    .o_out_flit   (out_flit),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_grant_id   (grant_id),
    .o_busy       (busy),
    .o_flit_count (flit_count),
    .o_pkt_count  (pkt_count),
    .o_pkt_err    (pkt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  vld;
    logic [3:0]  lst;
    logic [7:0]  seq;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [15:0] of;
    logic [1:0]  gid;
    logic        bsy;
    logic [31:0] fc;
    logic [31:0] pc;
    logic        err;
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] lst, input logic [7:0] seq,
                              input logic ordy, input logic [3:0] rdy, input logic ov,
                              input logic [15:0] of, input logic [1:0] gid, input logic bsy,
                              input int fc, input int pc, input logic err);
    vec_t v;
    v.vld = vld; v.lst = lst; v.seq = seq; v.ordy = ordy;
    v.rdy = rdy; v.ov = ov; v.of = of; v.gid = gid; v.bsy = bsy;
    v.fc = 32'(fc); v.pc = 32'(pc); v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] lst, input logic [7:0] seq,
                       input logic ordy);
    req_valid = vld;
    req_last  = lst;
    out_ready = ordy;
    for (int j = 0; j < int'(NR); j++) begin
      req_flit[j] = {8'(j), seq};
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Request ids 0..3 map to bits 0..3 of the vld/lst/rdy nibbles.
    tbl[0]  = mk(4'b1111, 4'b1111, 8'h01, 1, 4'b0001, 0, 16'h0000, 0, 0, 0, 0, 0);
    tbl[1]  = mk(4'b1111, 4'b1111, 8'h02, 1, 4'b0010, 1, 16'h0001, 0, 0, 1, 1, 0);
    tbl[2]  = mk(4'b1111, 4'b1111, 8'h03, 1, 4'b0100, 1, 16'h0102, 1, 0, 2, 2, 0);
    tbl[3]  = mk(4'b1111, 4'b1111, 8'h04, 1, 4'b1000, 1, 16'h0203, 2, 0, 3, 3, 0);
    tbl[4]  = mk(4'b1111, 4'b1111, 8'h05, 1, 4'b0001, 1, 16'h0304, 3, 0, 4, 4, 0);
    tbl[5]  = mk(4'b1111, 4'b1111, 8'h06, 1, 4'b0010, 1, 16'h0005, 0, 0, 5, 5, 0);
    tbl[6]  = mk(4'b1111, 4'b1111, 8'h07, 1, 4'b0100, 1, 16'h0106, 1, 0, 6, 6, 0);
    tbl[7]  = mk(4'b1111, 4'b1111, 8'h08, 1, 4'b1000, 1, 16'h0207, 2, 0, 7, 7, 0);
    tbl[8]  = mk(4'b0000, 4'b0000, 8'h09, 1, 4'b0000, 1, 16'h0308, 3, 0, 8, 8, 0);
    tbl[9]  = mk(4'b0000, 4'b0000, 8'h0a, 1, 4'b0000, 0, 16'h0308, 3, 0, 8, 8, 0);
    // Four-flit packet from req1; req0 joins on flit 2 and must wait.
    tbl[10] = mk(4'b0010, 4'b0000, 8'h10, 1, 4'b0010, 0, 16'h0308, 3, 0, 8, 8, 0);
    tbl[11] = mk(4'b0011, 4'b0000, 8'h11, 1, 4'b0010, 1, 16'h0110, 1, 1, 9, 8, 0);
    tbl[12] = mk(4'b0011, 4'b0000, 8'h12, 1, 4'b0010, 1, 16'h0111, 1, 1, 10, 8, 0);
    tbl[13] = mk(4'b0011, 4'b0010, 8'h13, 1, 4'b0010, 1, 16'h0112, 1, 1, 11, 8, 0);
    tbl[14] = mk(4'b0001, 4'b0001, 8'h14, 1, 4'b0001, 1, 16'h0113, 1, 0, 12, 9, 0);
    // Output stalled for five cycles with req2 waiting.
    tbl[15] = mk(4'b0100, 4'b0100, 8'h15, 0, 4'b0000, 1, 16'h0014, 0, 0, 13, 10, 0);
    tbl[16] = mk(4'b0100, 4'b0100, 8'h16, 0, 4'b0000, 1, 16'h0014, 0, 0, 13, 10, 0);
    tbl[17] = mk(4'b0100, 4'b0100, 8'h17, 0, 4'b0000, 1, 16'h0014, 0, 0, 13, 10, 0);
    tbl[18] = mk(4'b0100, 4'b0100, 8'h18, 0, 4'b0000, 1, 16'h0014, 0, 0, 13, 10, 0);
    tbl[19] = mk(4'b0100, 4'b0100, 8'h19, 0, 4'b0000, 1, 16'h0014, 0, 0, 13, 10, 0);
    tbl[20] = mk(4'b0100, 4'b0100, 8'h20, 1, 4'b0100, 1, 16'h0014, 0, 0, 13, 10, 0);
    tbl[21] = mk(4'b0000, 4'b0000, 8'h21, 1, 4'b0000, 1, 16'h0220, 2, 0, 14, 11, 0);
    tbl[22] = mk(4'b0000, 4'b0000, 8'h22, 1, 4'b0000, 0, 16'h0220, 2, 0, 14, 11, 0);
    // Runaway packet from req3, cut off by the watchdog after 4 flits.
    tbl[23] = mk(4'b1000, 4'b0000, 8'h23, 1, 4'b1000, 0, 16'h0220, 2, 0, 14, 11, 0);
    tbl[24] = mk(4'b1000, 4'b0000, 8'h24, 1, 4'b1000, 1, 16'h0323, 3, 1, 15, 11, 0);
    tbl[25] = mk(4'b1000, 4'b0000, 8'h25, 1, 4'b1000, 1, 16'h0324, 3, 1, 16, 11, 0);
    tbl[26] = mk(4'b1000, 4'b0000, 8'h26, 1, 4'b1000, 1, 16'h0325, 3, 1, 17, 11, 0);
    tbl[27] = mk(4'b1001, 4'b0001, 8'h27, 1, 4'b0001, 1, 16'h0326, 3, 0, 18, 12, 1);
    tbl[28] = mk(4'b1000, 4'b0000, 8'h28, 1, 4'b1000, 1, 16'h0027, 0, 0, 19, 13, 1);
    // Granted requester drops valid: lock holds, req0 stays blocked.
    tbl[29] = mk(4'b0000, 4'b0000, 8'h29, 1, 4'b1000, 1, 16'h0328, 3, 1, 20, 13, 1);
    tbl[30] = mk(4'b0001, 4'b0001, 8'h30, 1, 4'b1000, 0, 16'h0328, 3, 1, 20, 13, 1);

    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 8'h00, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-flit start-up.
    drive(4'b0001, 4'b0001, 8'h00, 1'b1);
    req_flit[0] = 16'h00a5;
    #1;
    chk("sf ready", 32'(req_ready), 32'h1);
    chk("sf ov pre", 32'(out_valid), 32'h0);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 8'h00, 1'b1);
    #1;
    chk("sf ov", 32'(out_valid), 32'h1);
    chk("sf flit", 32'(out_flit), 32'h00a5);
    chk("sf fc", flit_count, 32'd1);
    chk("sf pc", pkt_count, 32'd1);
    chk("sf busy", 32'(busy), 32'h0);

    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < int'(NV); i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].lst, tbl[i].seq, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("v%0d out_flit", i), 32'(out_flit), 32'(tbl[i].of));
      chk($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(tbl[i].gid));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("v%0d flit_count", i), flit_count, tbl[i].fc);
      chk($sformatf("v%0d pkt_count", i), pkt_count, tbl[i].pc);
      chk($sformatf("v%0d pkt_err", i), 32'(pkt_err), 32'(tbl[i].err));
    end

    // req3 is still locked with one flit in; take its second flit, stall, then reset.
    @(negedge clk);
    drive(4'b1000, 4'b0000, 8'h31, 1'b1);
    @(negedge clk);
    drive(4'b1000, 4'b0000, 8'h32, 1'b0);
    #1;
    chk("rm ov held", 32'(out_valid), 32'h1);
    chk("rm flit held", 32'(out_flit), 32'h0331);
    chk("rm fc pre", flit_count, 32'd21);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    drive(4'b1000, 4'b0000, 8'h33, 1'b1);
    #1;
    chk("rm ready in reset", 32'(req_ready), 32'h0);
    chk("rm ov in reset", 32'(out_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 8'h00, 1'b1);
    #1;
    chk("rm ov", 32'(out_valid), 32'h0);
    chk("rm busy", 32'(busy), 32'h0);
    chk("rm fc", flit_count, 32'd0);
    chk("rm pc", pkt_count, 32'd0);
    chk("rm err", 32'(pkt_err), 32'h0);
    chk("rm grant", 32'(grant_id), 32'h0);
    chk("rm flit", 32'(out_flit), 32'h0);
    @(negedge clk);
    drive(4'b0001, 4'b0001, 8'hbb, 1'b1);
    #1;
    chk("rm fresh ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    drive(4'b0000, 4'b0000, 8'h00, 1'b1);
    #1;
    chk("rm fresh ov", 32'(out_valid), 32'h1);
    chk("rm fresh flit", 32'(out_flit), 32'h00bb);
    chk("rm fresh fc", flit_count, 32'd1);
    chk("rm fresh pc", pkt_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end within the time limit");
    $fatal(1, "timeout");
  end

endmodule
